// File: rtl/rast_tri_arb_pkg.sv
// Shared rasterizer front-end parameters, payload types and small helpers
// used by the triangle dispatch arbiter.
package rast_tri_arb_pkg;

    localparam int unsigned SIGFIG        = 24;
    localparam int unsigned VERTS         = 3;
    localparam int unsigned AXIS          = 3;
    localparam int unsigned COLORS        = 3;
    localparam int unsigned TRI_ARB_BURST = 4;

    localparam int unsigned TRI_W   = VERTS * AXIS * SIGFIG;
    localparam int unsigned COLOR_W = COLORS * SIGFIG;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BURST_W = 4;

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

    typedef struct packed {
        tri_t   tri_v;
        color_t color;
        logic   src;
    } tri_slot_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Saturating increment for the per-requester delivery counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rast_tri_arb_rr_pick2.sv
// Two-way round-robin pick with a burst limit: keep the last winner while its
// run is short enough, otherwise hand over to the waiting requester.
module rast_rr_pick2
    import rast_tri_arb_pkg::*;
#(
    parameter int unsigned BURST = TRI_ARB_BURST
) (
    input  logic [1:0]         valid,
    input  logic               last,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic               sel_c,
    output logic               any_c
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST - 1);

    always_comb begin
        sel_c = 1'b0;
        any_c = |valid;
        case (valid)
            2'b01:   sel_c = 1'b0;
            2'b10:   sel_c = 1'b1;
            2'b11:   sel_c = (burst_cnt < BURST_LIM) ? last : ~last;
            default: sel_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/rast_tri_arb.sv
// Two-requester triangle dispatch arbiter in front of rast: round-robin with a
// burst limit, one-entry output register, honours rast halt back-pressure.
module rast_tri_arb
    import rast_tri_arb_pkg::*;
#(
    parameter int unsigned SIGFIG = rast_tri_arb_pkg::SIGFIG,
    parameter int unsigned VERTS  = rast_tri_arb_pkg::VERTS,
    parameter int unsigned AXIS   = rast_tri_arb_pkg::AXIS,
    parameter int unsigned COLORS = rast_tri_arb_pkg::COLORS,
    parameter int unsigned BURST  = TRI_ARB_BURST
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable_RnnnnH,
    input  logic [1:0][VERTS*AXIS*SIGFIG-1:0]         req_tri_S,
    input  logic [1:0][COLORS*SIGFIG-1:0]             req_color_U,
    input  logic [1:0]                                req_valid_H,
    output logic [1:0]                                req_ready_H,
    output logic signed [VERTS*AXIS*SIGFIG-1:0]       tri_R10S,
    output logic [COLORS*SIGFIG-1:0]                  color_R10U,
    output logic                                      validTri_R10H,
    input  logic                                      halt_RnnnnL,
    output logic [1:0][CNT_W-1:0]                     tri_count_U
);

    slot_state_e        state_q;
    logic               src_q;
    logic               last_q;
    logic [BURST_W-1:0] burst_cnt_q;

    logic sel_c;
    logic any_c;
    logic slot_free_c;
    logic take_c;
    logic deliver_c;

    rast_rr_pick2 #(
        .BURST (BURST)
    ) u_pick (
        .valid     (req_valid_H),
        .last      (last_q),
        .burst_cnt (burst_cnt_q),
        .sel_c     (sel_c),
        .any_c     (any_c)
    );

    assign validTri_R10H = (state_q == SLOT_FULL);

    // Handshake is the only combinational path; reset masks ready immediately.
    always_comb begin
        slot_free_c = !validTri_R10H || halt_RnnnnL;
        deliver_c   = validTri_R10H && halt_RnnnnL;
        take_c      = rst && enable_RnnnnH && slot_free_c && any_c;
        req_ready_H = {take_c && sel_c, take_c && !sel_c};
    end

    // Output register, arbiter history and delivery counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SLOT_EMPTY;
            tri_R10S    <= '0;
            color_R10U  <= '0;
            src_q       <= 1'b0;
            last_q      <= 1'b1;
            // Saturated so the first contested grant goes to requester 0.
            burst_cnt_q <= '1;
            tri_count_U <= '0;
        end else begin
            if (take_c) begin
                state_q    <= SLOT_FULL;
                tri_R10S   <= req_tri_S[sel_c];
                color_R10U <= req_color_U[sel_c];
                src_q      <= sel_c;
                if (sel_c == last_q) begin
                    if (burst_cnt_q != {BURST_W{1'b1}}) begin
                        burst_cnt_q <= burst_cnt_q + BURST_W'(1);
                    end
                end else begin
                    last_q      <= sel_c;
                    burst_cnt_q <= '0;
                end
            end else if (deliver_c) begin
                state_q <= SLOT_EMPTY;
            end
            if (deliver_c) begin
                tri_count_U[src_q] <= sat_inc(tri_count_U[src_q]);
            end
        end
    end

endmodule
